// File: rtl/rotary_step_ctrl.sv
// rtl/rotary_step_ctrl.sv - Filtered quadrature decoder driving per-mode stepped table addresses
module rotary_step_ctrl #(
    parameter int ADDR_W     = 11,
    parameter int NUM_CH     = 5,
    parameter int FILT_LEN   = 8,
    parameter int STEP_LVLS  = 3,
    parameter int STEP_SHIFT = 3,
    parameter int ADDR_MAX   = 2047,
    parameter int RESET_ADDR = 0,
    parameter int WRAP       = 0
) (
    input  logic              Fg_clk,
    input  logic              Resetn,
    input  logic              Rot_A,
    input  logic              Rot_B,
    input  logic              Rot_C,
    input  logic [2:0]        Mode,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        Step_Lvl,
    output logic              FreqChng
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int SUM_W = ADDR_W + 2;
    localparam logic [SUM_W-1:0] L_MAX = SUM_W'(ADDR_MAX);
    localparam logic [SUM_W-1:0] L_MOD = SUM_W'(ADDR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CW1, S_CW2, S_CW3, S_CCW1, S_CCW2, S_CCW3, S_ERR
    } state_t;

    // Bit 1 carries phase A, bit 0 phase B, so {A,B} reads directly as the quadrature code.
    logic [1:0]        r_meta;
    logic [1:0]        r_sync;
    logic [1:0]        r_filt;
    logic [CNT_W-1:0]  r_cnt [2];
    state_t            r_state;
    state_t            w_next;
    logic              w_det_up;
    logic              w_det_dn;
    logic [ADDR_W-1:0] r_ch [NUM_CH];
    logic [1:0]        r_lvl;
    logic [2:0]        r_mode;
    logic              r_freq;
    logic              w_mode_ok;
    logic [2:0]        w_sel;
    logic [ADDR_W-1:0] w_cur;
    logic [SUM_W-1:0]  w_step;
    logic [SUM_W-1:0]  w_up;
    logic [SUM_W-1:0]  w_dn;
    logic [ADDR_W-1:0] w_up_res;
    logic [ADDR_W-1:0] w_dn_res;
    logic [ADDR_W-1:0] w_new;
    logic              w_apply;
    logic              w_changed;
    logic              w_mode_chg;

    // Two-flop synchroniser for the asynchronous encoder phases; idle level is high.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            r_meta <= 2'b11;
            r_sync <= 2'b11;
        end else begin
            r_meta <= {Rot_A, Rot_B};
            r_sync <= r_meta;
        end
    end

    // Accept a new level only after FILT_LEN consecutive synchronised samples disagree with the current one.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            r_filt <= 2'b11;
            for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(FILT_LEN - 1)) begin
                    r_filt[i] <= r_sync[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Decoder transitions: full cycles emit a detent, reversals back up, two-bit jumps park in ERR until 11.
    always_comb begin
        w_next   = r_state;
        w_det_up = 1'b0;
        w_det_dn = 1'b0;
        case (r_state)
            S_IDLE: case (r_filt)
                2'b10: w_next = S_CW1;
                2'b01: w_next = S_CCW1;
                2'b00: w_next = S_ERR;
                default: ;
            endcase
            S_CW1: case (r_filt)
                2'b00: w_next = S_CW2;
                2'b11: w_next = S_IDLE;
                2'b01: w_next = S_ERR;
                default: ;
            endcase
            S_CW2: case (r_filt)
                2'b01: w_next = S_CW3;
                2'b10: w_next = S_CW1;
                2'b11: w_next = S_ERR;
                default: ;
            endcase
            S_CW3: case (r_filt)
                2'b11: begin w_next = S_IDLE; w_det_up = 1'b1; end
                2'b00: w_next = S_CW2;
                2'b10: w_next = S_ERR;
                default: ;
            endcase
            S_CCW1: case (r_filt)
                2'b00: w_next = S_CCW2;
                2'b11: w_next = S_IDLE;
                2'b10: w_next = S_ERR;
                default: ;
            endcase
            S_CCW2: case (r_filt)
                2'b10: w_next = S_CCW3;
                2'b01: w_next = S_CCW1;
                2'b11: w_next = S_ERR;
                default: ;
            endcase
            S_CCW3: case (r_filt)
                2'b11: begin w_next = S_IDLE; w_det_dn = 1'b1; end
                2'b00: w_next = S_CCW2;
                2'b01: w_next = S_ERR;
                default: ;
            endcase
            S_ERR: if (r_filt == 2'b11) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_mode_ok  = (32'(Mode) < NUM_CH);
    assign w_sel      = w_mode_ok ? Mode : 3'd0;
    assign w_cur      = r_ch[w_sel];
    assign w_step     = SUM_W'(1) << (STEP_SHIFT * int'(r_lvl));
    // Two spare bits: one for the carry past ADDR_MAX, one as the sign of an underflow.
    assign w_up       = {2'b00, w_cur} + w_step;
    assign w_dn       = {2'b00, w_cur} - w_step;
    assign w_apply    = (w_det_up | w_det_dn) & w_mode_ok;
    assign w_changed  = w_apply && (w_new != w_cur);
    assign w_mode_chg = w_mode_ok && (Mode != r_mode);

    // Bound the stepped address: clamp to 0/ADDR_MAX or fold modulo ADDR_MAX+1.
    always_comb begin
        w_up_res = ADDR_W'(w_up);
        w_dn_res = ADDR_W'(w_dn);
        w_new    = w_cur;
        if (w_up > L_MAX) w_up_res = (WRAP != 0) ? ADDR_W'(w_up - L_MOD) : ADDR_W'(L_MAX);
        if (w_dn[SUM_W-1]) w_dn_res = (WRAP != 0) ? ADDR_W'(w_dn + L_MOD) : '0;
        if (w_det_up)      w_new = w_up_res;
        else if (w_det_dn) w_new = w_dn_res;
    end

    // Channel registers, step level, mode history and the reload pulse.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NUM_CH; i++) r_ch[i] <= ADDR_W'(RESET_ADDR);
            r_lvl  <= 2'd0;
            r_mode <= 3'd0;
            r_freq <= 1'b0;
        end else begin
            if (w_apply) r_ch[w_sel] <= w_new;
            r_freq <= w_changed | w_mode_chg;
            r_mode <= Mode;
            if (Rot_C) r_lvl <= (r_lvl == 2'(STEP_LVLS - 1)) ? 2'd0 : r_lvl + 2'd1;
        end
    end

    assign address  = w_cur;
    assign Step_Lvl = r_lvl;
    assign FreqChng = r_freq;

endmodule
